// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: exhaustive stimulus engine for small combinational circuits.
// Walks every input vector in ascending order and holds each one for HOLD cycles.
// On the last cycle of each hold it samples the DUT output and compares it against
// the expected minterm mask that was latched at start.
// It records the observed mask, an error count and the first failing vector.
module truth_table_sweeper #(
    parameter int N_IN = 4,
    parameter int HOLD = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [(1<<N_IN)-1:0]   exp_mask,
    output logic [N_IN-1:0]        vec,
    input  logic                   y_in,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [N_IN:0]          err_count,
    output logic                   first_err_valid,
    output logic [N_IN-1:0]        first_err_vec,
    output logic [(1<<N_IN)-1:0]   obs_mask
);

    localparam int NV = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST_VEC    = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] VEC_ONE     = N_IN'(1'b1);
    localparam logic [N_IN-1:0] VEC_ZERO    = {N_IN{1'b0}};
    localparam logic [N_IN:0]   ERR_ZERO    = {(N_IN+1){1'b0}};
    localparam logic [N_IN:0]   ERR_ONE     = (N_IN+1)'(1'b1);
    // Every vector failing gives exactly 2^N_IN; the counter never goes past it.
    localparam logic [N_IN:0]   ERR_MAX     = {1'b1, {N_IN{1'b0}}};
    localparam logic [7:0]      SETTLE_LAST = 8'(HOLD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_r;
    logic [7:0]        settle_r;
    logic [NV-1:0]     exp_r;
    logic              mismatch_s;
    logic [N_IN:0]     err_next_s;

    // Compare the DUT output against the latched expectation and form the next error count.
    always_comb begin
        mismatch_s = 1'b0;
        err_next_s = err_count;
        mismatch_s = (y_in != exp_r[vec]);
        if (mismatch_s && (err_count != ERR_MAX)) begin
            err_next_s = err_count + ERR_ONE;
        end else begin
            err_next_s = err_count;
        end
    end

    // Sweep controller: state, stimulus vector, settle counter and all result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= IDLE;
            settle_r        <= 8'd0;
            exp_r           <= {NV{1'b0}};
            vec             <= VEC_ZERO;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= ERR_ZERO;
            first_err_valid <= 1'b0;
            first_err_vec   <= VEC_ZERO;
            obs_mask        <= {NV{1'b0}};
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    // start wins over abort outside a sweep; abort alone does nothing here
                    if (start) begin
                        state_r         <= SWEEP;
                        settle_r        <= 8'd0;
                        exp_r           <= exp_mask;
                        vec             <= VEC_ZERO;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        err_count       <= ERR_ZERO;
                        first_err_valid <= 1'b0;
                        first_err_vec   <= VEC_ZERO;
                        obs_mask        <= {NV{1'b0}};
                    end
                end
                SWEEP: begin
                    if (abort) begin
                        // partial results stay visible after an abort
                        state_r  <= IDLE;
                        settle_r <= 8'd0;
                        vec      <= VEC_ZERO;
                        busy     <= 1'b0;
                        done     <= 1'b0;
                    end else if (settle_r == SETTLE_LAST) begin
                        settle_r      <= 8'd0;
                        obs_mask[vec] <= y_in;
                        err_count     <= err_next_s;
                        if (mismatch_s && !first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_vec   <= vec;
                        end
                        if (vec == LAST_VEC) begin
                            // the last sample's mismatch is already folded into err_next_s
                            state_r <= DONE;
                            vec     <= VEC_ZERO;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= (err_next_s == ERR_ZERO);
                        end else begin
                            vec <= vec + VEC_ONE;
                        end
                    end else begin
                        settle_r <= settle_r + 8'd1;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    settle_r <= 8'd0;
                    vec      <= VEC_ZERO;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Self-checking exhaustive stimulus engine for small combinational lab circuits (gate-level and operator-style functions of 2..8 inputs).
- Drives every input combination 0..2^N_IN-1 in ascending binary order (MSB = input A), holds each vector for a settle interval, then samples the DUT output.
- Compares each sample against an expected minterm mask, records the observed mask, error count and first failing vector.
- Sits beside the DUT in lab top-levels and replaces hand-written per-row truth-table stimulus.

Parameters:
- N_IN, 4, number of DUT inputs; legal range 1..8.
- HOLD, 1, clock cycles each vector is held before sampling; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE.
- abort  input  1  terminates a sweep in progress.
- exp_mask  input  2^N_IN  expected output; bit k = expected Y for input vector k.
- vec  output  N_IN  stimulus to DUT; vec[N_IN-1] = A.
- y_in  input  1  DUT output.
- busy  output  1  high while a sweep is running.
- done  output  1  high from sweep completion until the next start or reset.
- pass  output  1  valid while done: 1 iff err_count == 0.
- err_count  output  N_IN+1  number of mismatching vectors, saturates at 2^N_IN.
- first_err_valid  output  1  at least one mismatch has been seen in this sweep.
- first_err_vec  output  N_IN  lowest-index mismatching vector.
- obs_mask  output  2^N_IN  observed Y per vector.

Behaviour:
- Reset (synchronous, active-high, overrides all other inputs):
  - State goes to IDLE.
  - vec, busy, done, pass, err_count, first_err_valid, first_err_vec and obs_mask all go to 0.
- States: IDLE, SWEEP, DONE. A HOLD-wide settle counter runs only in SWEEP.
- Start:
  - start=1 in IDLE or DONE at edge t0 moves the block to SWEEP.
  - At t0: exp_mask is latched internally, vec=0, settle=0, busy=1, done=0, pass=0, err_count=0, first_err_valid=0, first_err_vec=0, obs_mask=0.
  - exp_mask changes after t0 do not affect the running sweep.
- SWEEP:
  - settle increments every cycle.
  - At the edge where settle == HOLD-1, y_in is sampled for the current vec:
    - obs_mask[vec] <= y_in.
    - On mismatch with latched exp[vec], err_count increments.
    - On the first mismatch, first_err_vec <= vec and first_err_valid <= 1.
  - On the same edge, settle resets to 0 and vec increments.
  - Vector k is therefore sampled at edge t0+(k+1)*HOLD and is stable on vec for exactly HOLD cycles.
- Completion:
  - The sample of vector 2^N_IN-1 occurs at edge t0+2^N_IN*HOLD.
  - On that edge: state goes to DONE, busy=0, done=1, pass=(final err_count==0), vec wraps to 0.
  - A mismatch on the last vector is included in pass.
- DONE: all result outputs hold until start or reset.
- start while SWEEP is ignored; the sweep is not restarted.
- abort in SWEEP:
  - Next state IDLE, busy=0, done=0, vec=0.
  - err_count, first_err_*, obs_mask hold their partial values.
  - abort in IDLE or DONE has no effect.
- abort and start asserted on the same edge:
  - In SWEEP, abort wins.
  - In IDLE or DONE, start wins.
- Reset during SWEEP: same as reset at any time; no partial results are kept.
- err_count saturation is reachable only when every vector fails; err_count = 2^N_IN exactly, with no wrap.
- No combinational path from y_in to any output; all outputs are registered.

Test Plan:
- N_IN=3, HOLD=1, DUT = majority(A,B,C), exp_mask=8'hE8, pulse start → vec steps 0..7 one per cycle; done=1 and pass=1 at exactly 8 cycles after the start edge; err_count=0; obs_mask=8'hE8.
- Same DUT, exp_mask=8'hE9 → done after 8 cycles; pass=0; err_count=1; first_err_valid=1; first_err_vec=3'd0; obs_mask=8'hE8.
- Same DUT, exp_mask=8'h17 (fully inverted) → err_count=4'd8 (saturated, no wrap); first_err_vec=0; pass=0.
- N_IN=4, HOLD=3, DUT Y=A^B^C^D, exp_mask=16'h6996 → each vec value held 3 cycles; done 48 cycles after start; pass=1; start pulsed at cycle 10 has no effect.
- N_IN=4, abort asserted while vec=5 → next cycle state IDLE, busy=0, done=0, vec=0; obs_mask bits 0..4 retained. A following start completes a full sweep with pass correct.
- Reset asserted while vec=6 in SWEEP → next cycle all outputs 0. start together with abort in IDLE → sweep begins.
